// File: rtl/status_change_serializer_if.sv
// Update stream from the status change serializer: one valid/ready
// handshake carrying a channel index and its new status value.
interface status_change_serializer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CH_WIDTH   = 2
);
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [CH_WIDTH-1:0]   out_ch;

  modport master (
    output out_valid,
    output out_data,
    output out_ch,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_ch,
    output out_ready
  );
endinterface

// File: rtl/status_change_serializer.sv
// Serializes per-channel status changes onto one round-robin update stream.
// Define STATUS_SERIALIZER_DROP_CNT_EN to build the per-channel overwrite counters.
module status_change_serializer #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int CH_WIDTH     = 2,
  parameter int ACCUMULATE   = 0
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_in,
  status_change_serializer_if.master       out_if,
  output logic [NUM_CHANNELS-1:0]          pending,
  output logic [NUM_CHANNELS*8-1:0]        drop_cnt
);

  if (((1 << CH_WIDTH) < NUM_CHANNELS) ||
      (NUM_CHANNELS < 2) || (NUM_CHANNELS > 16)) begin : g_bad_cfg
    $error("status_change_serializer: bad NUM_CHANNELS/CH_WIDTH");
  end

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] hold_q [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0] last_q [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0] new_hold [NUM_CHANNELS];
  logic [CH_WIDTH-1:0]   rr_q;
  logic [CH_WIDTH-1:0]   gnt;
  logic [DATA_WIDTH-1:0] gnt_data;
  logic                  gnt_v;
  logic                  grant_now;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [CH_WIDTH-1:0]   ch_q;
  int                    idx;

  assign out_if.out_valid = valid_q;
  assign out_if.out_data  = data_q;
  assign out_if.out_ch    = ch_q;

  // Walk from the highest offset down so the first pending channel
  // after the round-robin pointer wins.
  always_comb begin
    gnt      = '0;
    gnt_data = '0;
    gnt_v    = 1'b0;
    idx      = 0;
    for (int i = NUM_CHANNELS-1; i >= 0; i--) begin
      idx = int'(rr_q) + i;
      if (idx >= NUM_CHANNELS) idx = idx - NUM_CHANNELS;
      if (pending[idx]) begin
        gnt      = CH_WIDTH'(idx);
        gnt_data = hold_q[idx];
        gnt_v    = 1'b1;
      end
    end
  end

  assign grant_now = (state_q == IDLE) && gnt_v;

  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      new_hold[c] = data_in[c*DATA_WIDTH +: DATA_WIDTH];
      if (ACCUMULATE != 0) new_hold[c] = new_hold[c] | hold_q[c];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
      ch_q    <= '0;
      rr_q    <= '0;
      pending <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        hold_q[c] <= '0;
        last_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (grant_now && (gnt == CH_WIDTH'(c))) begin
          pending[c] <= 1'b0;
          last_q[c]  <= hold_q[c];
        end else if (pending[c]) begin
          hold_q[c] <= new_hold[c];
        end else if (data_in[c*DATA_WIDTH +: DATA_WIDTH] != last_q[c]) begin
          pending[c] <= 1'b1;
          hold_q[c]  <= data_in[c*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      unique case (state_q)
        IDLE: begin
          if (grant_now) begin
            valid_q <= 1'b1;
            data_q  <= gnt_data;
            ch_q    <= gnt;
            rr_q    <= (gnt == CH_WIDTH'(NUM_CHANNELS-1)) ?
                       '0 : gnt + CH_WIDTH'(1);
            state_q <= SEND;
          end
        end
        SEND: begin
          if (valid_q && out_if.out_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef STATUS_SERIALIZER_DROP_CNT_EN
  logic [NUM_CHANNELS-1:0] drop_ev;
  logic [7:0]              drop_q [NUM_CHANNELS];

  // A drop is a pending value overwritten by a different one.
  always_comb begin
    drop_ev = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      drop_ev[c] = pending[c] &&
                   !(grant_now && (gnt == CH_WIDTH'(c))) &&
                   (new_hold[c] != hold_q[c]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CHANNELS; c++) drop_q[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (drop_ev[c] && (drop_q[c] != 8'hFF))
          drop_q[c] <= drop_q[c] + 8'd1;
      end
    end
  end

  always_comb begin
    drop_cnt = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) drop_cnt[c*8 +: 8] = drop_q[c];
  end
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_status_change_serializer.sv
// Directed bench for status_change_serializer, latest-wins and
// accumulate builds driven side by side from the same stimulus.
module tb_status_change_serializer;

`ifdef STATUS_SERIALIZER_DROP_CNT_EN
  localparam int DROP_EN = 1;
`else
  localparam int DROP_EN = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] data_in;
  logic        ready;
  logic [3:0]  pend_a;
  logic [3:0]  pend_b;
  logic [31:0] drop_a;
  logic [31:0] drop_b;
  int          checks = 0;
  int          errors = 0;

  status_change_serializer_if #(.DATA_WIDTH(8), .CH_WIDTH(2)) if_a ();
  status_change_serializer_if #(.DATA_WIDTH(8), .CH_WIDTH(2)) if_b ();

  assign if_a.out_ready = ready;
  assign if_b.out_ready = ready;

  status_change_serializer #(
    .DATA_WIDTH(8), .NUM_CHANNELS(4), .CH_WIDTH(2), .ACCUMULATE(0)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .data_in(data_in),
    .out_if(if_a), .pending(pend_a), .drop_cnt(drop_a)
  );

  status_change_serializer #(
    .DATA_WIDTH(8), .NUM_CHANNELS(4), .CH_WIDTH(2), .ACCUMULATE(1)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .data_in(data_in),
    .out_if(if_b), .pending(pend_b), .drop_cnt(drop_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v,
                         input logic [1:0] ch, input logic [7:0] d);
    chk({tag, "_valid"}, 32'(if_a.out_valid), 32'(v));
    if (v) begin
      chk({tag, "_ch"}, 32'(if_a.out_ch), 32'(ch));
      chk({tag, "_data"}, 32'(if_a.out_data), 32'(d));
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    data_in = '0;
    ready   = 1'b1;
    tick();
    tick();
    chk("rst_valid", 32'(if_a.out_valid), 32'd0);
    chk("rst_data", 32'(if_a.out_data), 32'd0);
    chk("rst_ch", 32'(if_a.out_ch), 32'd0);
    chk("rst_pend", 32'(pend_a), 32'd0);
    chk("rst_drop", drop_a, 32'd0);

    // single change on ch1: pending after N, update after N+1, one pulse
    reset_n = 1'b1;
    tick();
    data_in[15:8] = 8'h5A;
    tick();
    chk("lat_pend", 32'(pend_a), 32'b0010);
    chk("lat_nvalid", 32'(if_a.out_valid), 32'd0);
    tick();
    chk_out("lat", 1'b1, 2'd1, 8'h5A);
    chk("lat_pend_clr", 32'(pend_a), 32'd0);
    tick();
    chk("lat_pulse", 32'(if_a.out_valid), 32'd0);
    tick();
    chk("lat_no_repeat", 32'(if_a.out_valid), 32'd0);

    // all four channels at once: order ch0..ch3 after reset
    do_reset();
    data_in = 32'h44332211;
    tick();
    chk("rr_pend", 32'(pend_a), 32'b1111);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_out("rr", 1'b1, 2'(k), 8'(8'h11 * (k + 1)));
      tick();
      chk("rr_gap", 32'(if_a.out_valid), 32'd0);
    end

    // stall on ch2 while ch2 keeps changing
    ready = 1'b0;
    data_in[23:16] = 8'h77;
    tick();
    chk("stall_pend", 32'(pend_a), 32'b0100);
    tick();
    chk_out("stall_grant", 1'b1, 2'd2, 8'h77);
    for (int i = 0; i < 10; i++) begin
      data_in[23:16] = 8'(8'h80 + i);
      tick();
      chk_out("stall_hold", 1'b1, 2'd2, 8'h77);
    end
    chk("stall_repend", 32'(pend_a), 32'b0100);
    ready = 1'b1;
    tick();
    chk("stall_acc", 32'(if_a.out_valid), 32'd0);
    tick();
    chk_out("stall_next", 1'b1, 2'd2, 8'h89);
    tick();

    // accumulate vs latest-wins on ch0 while ch1 occupies the output
    do_reset();
    ready = 1'b0;
    data_in = 32'h00009900;
    tick();
    tick();
    chk_out("acc_blk", 1'b1, 2'd1, 8'h99);
    data_in[7:0] = 8'h01;
    tick();
    data_in[7:0] = 8'h04;
    tick();
    chk("acc_pend", 32'(pend_a), 32'b0001);
    ready = 1'b1;
    tick();
    tick();
    chk_out("acc0", 1'b1, 2'd0, 8'h04);
    chk("acc1_ch", 32'(if_b.out_ch), 32'd0);
    chk("acc1_data", 32'(if_b.out_data), 32'h05);
    chk("acc_drop", 32'(drop_a[7:0]), 32'(DROP_EN));
    tick();

    // ch3 overwritten 300 times while blocked
    do_reset();
    ready = 1'b0;
    data_in = 32'h00009900;
    tick();
    tick();
    data_in[31:24] = 8'h01;
    tick();
    for (int i = 0; i < 300; i++) begin
      data_in[31:24] = 8'(i + 2);
      tick();
    end
    chk("drop_sat", 32'(drop_a[31:24]), 32'(DROP_EN * 255));
    chk("drop_ch1", 32'(drop_a[15:8]), 32'd0);
    chk("drop_blk", 32'(if_a.out_valid), 32'd1);

    // reset while stalled in SEND
    reset_n = 1'b0;
    tick();
    chk("mrst_valid", 32'(if_a.out_valid), 32'd0);
    chk("mrst_pend", 32'(pend_a), 32'd0);
    chk("mrst_drop", drop_a, 32'd0);
    data_in = '0;
    reset_n = 1'b1;
    tick();
    tick();
    chk("mrst_idle", 32'(if_a.out_valid), 32'd0);
    chk("mrst_pend2", 32'(pend_a), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/status_change_serializer.md
STATUS_CHANGE_SERIALIZER -- requirements
Module: status_change_serializer

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of each channel's status vector.
REQ-002 Parameter NUM_CHANNELS, default 4, range 2..16: number of independent input channels.
REQ-003 Parameter CH_WIDTH, default 2: width of channel index; the block SHALL require 2**CH_WIDTH >= NUM_CHANNELS.
REQ-004 Parameter ACCUMULATE, default 0: 0 = latest value wins while pending; 1 = bitwise OR-accumulate while pending.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 reset_n  input  1  synchronous, active-low reset.
REQ-007 data_in  input  NUM_CHANNELS*DATA_WIDTH  channel i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 out_valid  output  1  out_data/out_ch hold a valid update.
REQ-009 out_ready  input  1  downstream accepts the update when high with out_valid.
REQ-010 out_data  output  DATA_WIDTH  update value.
REQ-011 out_ch  output  CH_WIDTH  channel index of update.
REQ-012 pending  output  NUM_CHANNELS  per-channel pending flag.
REQ-013 drop_cnt  output  NUM_CHANNELS*8  per-channel overwrite counter, channel i at [i*8 +: 8].

Function
REQ-014 Per channel the block SHALL keep last_sent (value last granted), hold (value awaiting send) and a pending bit.
REQ-015 Channel not pending and data_in != last_sent at edge N: pending=1 and hold=data_in after edge N.
REQ-016 Channel pending and not granted: ACCUMULATE=0 -> hold=data_in each cycle; ACCUMULATE=1 -> hold=hold|data_in each cycle.
REQ-017 FSM states IDLE and SEND; IDLE with any pending bit set -> grant one channel, go to SEND; otherwise stay in IDLE.
REQ-018 Grant SHALL be round-robin: search starts at channel (last_grant+1) mod NUM_CHANNELS, wrapping; after reset the search starts at channel 0.
REQ-019 At the grant edge: out_data=hold[g], out_ch=g, out_valid=1, pending[g]=0, last_sent[g]=hold[g].
REQ-020 Latency: input change before edge N with FSM IDLE and no other pending -> out_valid high after edge N+1.
REQ-021 In SEND, out_valid/out_data/out_ch SHALL remain stable until out_valid&&out_ready; then out_valid=0, state IDLE (one idle cycle minimum between updates).
REQ-022 data_in change on granted channel in the grant cycle SHALL be detected the next cycle against the updated last_sent; if equal to the granted value no new event occurs.
REQ-023 A value restored to last_sent while pending SHALL still be sent (pending is not withdrawn).
REQ-024 Drop event: channel pending, not granted this cycle, and the new hold value differs from the current hold.

Reset
REQ-025 reset_n low at an edge: out_valid=0, out_data=0, out_ch=0, pending=0, all hold/last_sent=0, drop_cnt=0, state IDLE, round-robin pointer to channel 0.
REQ-026 Reset mid-transfer SHALL abandon the update without out_ready; no update is re-sent after reset unless data_in differs from 0.

Configuration
REQ-027 With STATUS_SERIALIZER_DROP_CNT_EN defined: each drop event increments that channel's drop_cnt, saturating at 255, cleared only by reset.
REQ-028 Without STATUS_SERIALIZER_DROP_CNT_EN: drop_cnt SHALL be constant 0 and no counter logic instantiated; all other behaviour identical.

Verification
REQ-029 Reset release, data_in ch1=0x5A, out_ready=1 -> pending[1] after edge N, out_valid with out_ch=1, out_data=0x5A after edge N+1, one-cycle pulse.
REQ-030 ch0..ch3 change same cycle to 0x11,0x22,0x33,0x44, out_ready=1 -> updates emitted in order ch0,ch1,ch2,ch3 with matching data.
REQ-031 out_ready=0 for 10 cycles during SEND while ch2 input changes -> out_valid/out_data/out_ch stable for all 10 cycles.
REQ-032 ACCUMULATE=1, ch0 pending, out_ready=0, inputs 0x01 then 0x04 -> ch0 update carries 0x05; ACCUMULATE=0 -> carries 0x04.
REQ-033 Macro defined, ch3 pending and blocked, 300 distinct input changes -> drop_cnt ch3 = 255; macro undefined -> 0.
REQ-034 reset_n low during SEND with out_ready=0 -> out_valid=0 and pending=0 after the reset edge.
